// File: rtl/iobus_arbiter.sv
// iobus_arbiter: round-robin sharing of the OTTER IOBUS between two requesters
module iobus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_req_i,
  input  logic        m0_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_wr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_rdata_o,
  input  logic [31:0] iobus_in_i,
  output logic [31:0] iobus_addr_o,
  output logic [31:0] iobus_out_o,
  output logic        iobus_wr_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d, last_q, last_d, wr_q, wr_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          pick_m1;

  // on a tie the requester that was not served last wins
  assign pick_m1 = m1_req_i & (~m0_req_i | ~last_q);

  // state and datapath registers; last_gnt resets to M1 so M0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // next state: grant and latch in IDLE, count wait cycles in BUSY, capture read data on DONE entry
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (m0_req_i || m1_req_i) begin
        state_d = BUSY;
        cnt_d   = '0;
        gnt_d   = pick_m1;
        last_d  = pick_m1;
        wr_d    = pick_m1 ? m1_wr_i : m0_wr_i;
        addr_d  = pick_m1 ? m1_addr_i : m0_addr_i;
        wdata_d = pick_m1 ? m1_wdata_i : m0_wdata_i;
      end
      BUSY: if (cnt_q == CNT_MAX) begin
        state_d  = DONE;
        rdata0_d = (!wr_q && !gnt_q) ? iobus_in_i : rdata0_q;
        rdata1_d = (!wr_q && gnt_q) ? iobus_in_i : rdata1_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs decode registered state only, so no input reaches an output combinationally
  always_comb begin
    iobus_addr_o = (state_q == BUSY) ? addr_q : '0;
    iobus_out_o  = (state_q == BUSY && wr_q) ? wdata_q : '0;
    iobus_wr_o   = state_q == BUSY && wr_q && cnt_q == '0;
    m0_ack_o     = state_q == DONE && !gnt_q;
    m1_ack_o     = state_q == DONE && gnt_q;
    m0_rdata_o   = rdata0_q;
    m1_rdata_o   = rdata1_q;
  end
endmodule
